alu_issue_stage: RTL

//  ID->EX issue stage directly upstream of the ALU: decodes RV32I opcode/funct3/funct7[5] into the 4-bit ALU op,

---
 rtl/riscv_alu_pkg.sv | 49 ++++
 rtl/alu_op_decode.sv | 29 ++
 rtl/alu_issue_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/riscv_alu_pkg.sv
// rtl/riscv_alu_pkg.sv - shared ALU op codes, RV32I opcodes and issue entry type
package riscv_alu_pkg;

  localparam int XLEN   = 32;
  localparam int RADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // One issued operation as held in the output register or the skid slot.
  typedef struct packed {
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    alu_op_e            op;
    logic [RADDR_W-1:0] rd;
    logic               illegal;
  } issue_entry_t;

  // funct3/funct7[5] -> ALU op; funct7[5] selects SUB only for register-register ops.
  function automatic alu_op_e arith_op(input logic [2:0] funct3, input logic funct7_5,
                                       input logic is_reg);
    case (funct3)
      3'b000:  arith_op = (is_reg && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational RV32I opcode/funct to ALU op decode
module alu_op_decode
  import riscv_alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_e    op,
  output logic       use_imm,
  output logic       illegal
);

  // Unknown opcodes still issue as an ADD with the immediate, flagged illegal.
  always_comb begin
    op      = ALU_ADD;
    use_imm = 1'b1;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        op      = arith_op(funct3, funct7_5, 1'b1);
        use_imm = 1'b0;
      end
      OPC_OP_IMM: op = arith_op(funct3, funct7_5, 1'b0);
      OPC_LOAD, OPC_STORE: op = ALU_ADD;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID->EX issue stage with decode, bypass (ALU_ISSUE_FWD_EN) and skid buffer
module alu_issue_stage
  import riscv_alu_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int REG_AW = RADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rs1_data,
  input  logic [WIDTH-1:0]  rs2_data,
  input  logic [WIDTH-1:0]  imm,
  input  logic              fwd_mem_we,
  input  logic [REG_AW-1:0] fwd_mem_rd,
  input  logic [WIDTH-1:0]  fwd_mem_data,
  input  logic              fwd_wb_we,
  input  logic [REG_AW-1:0] fwd_wb_rd,
  input  logic [WIDTH-1:0]  fwd_wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [3:0]        alu_op,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_illegal
);

  alu_op_e      dec_op;
  logic         dec_use_imm;
  logic         dec_illegal;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  issue_entry_t cap;
  issue_entry_t out_q;
  issue_entry_t skid_q;
  logic         skid_valid;
  logic         accept;

  alu_op_decode u_decode (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .op       (dec_op),
    .use_imm  (dec_use_imm),
    .illegal  (dec_illegal)
  );

`ifdef ALU_ISSUE_FWD_EN
  // Youngest producer (EX/MEM) wins; x0 is hard-wired zero and never bypassed.
  function automatic logic [WIDTH-1:0] bypass(input logic [REG_AW-1:0] addr,
                                              input logic [WIDTH-1:0] rf_data);
    if (fwd_mem_we && (fwd_mem_rd == addr) && (addr != '0))
      bypass = fwd_mem_data;
    else if (fwd_wb_we && (fwd_wb_rd == addr) && (addr != '0))
      bypass = fwd_wb_data;
    else
      bypass = rf_data;
  endfunction

  assign src1 = bypass(rs1_addr, rs1_data);
  assign src2 = bypass(rs2_addr, rs2_data);
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                        fwd_wb_we, fwd_wb_rd, fwd_wb_data, rs1_addr, rs2_addr};
  assign src1 = rs1_data;
  assign src2 = rs2_data;
`endif

  assign accept = in_valid && in_ready;

  // Assemble the entry captured on accept; immediate ops ignore the rs2 path entirely.
  always_comb begin
    cap         = '0;
    cap.a       = src1;
    cap.b       = dec_use_imm ? imm : src2;
    cap.op      = dec_op;
    cap.rd      = rd_addr;
    cap.illegal = dec_illegal;
  end

  // Output register plus one skid slot; skid drains into the output before new accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else if (accept) begin
        out_q     <= cap;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= cap;
      skid_valid <= 1'b1;
      in_ready   <= 1'b0;
    end
  end

  assign alu_a       = out_q.a;
  assign alu_b       = out_q.b;
  assign alu_op      = out_q.op;
  assign out_rd      = out_q.rd;
  assign out_illegal = out_q.illegal;

endmodule
